// File: rtl/mux_arb_nx1_if.sv
// Producer/consumer bundle for mux_arb_nx1.
// The slave side is the multiplexer. The master side drives the producers and the consumer.
interface mux_arb_nx1_if #(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] DIN;
  logic [N-1:0]   VLD_IN;
  logic [N-1:0]   RDY_IN;
  logic [SW-1:0]  SEL;
  logic           MODE;
  logic [W-1:0]   F;
  logic           F_VLD;
  logic           F_RDY;
  logic [N-1:0]   GNT;

  modport master (
    output DIN, VLD_IN, SEL, MODE, F_RDY,
    input  RDY_IN, F, F_VLD, GNT
  );

  modport slave (
    input  DIN, VLD_IN, SEL, MODE, F_RDY,
    output RDY_IN, F, F_VLD, GNT
  );
endinterface

// File: rtl/mux_arb_nx1.sv
// Registered N:1 multiplexer with a valid/ready handshake on each channel.
// The source channel comes from an external select or from round-robin arbitration.
module mux_arb_nx1 #(
  parameter int N = 4,
  parameter int W = 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  mux_arb_nx1_if.slave  bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  logic [W-1:0]  f_reg;
  logic          f_vld_reg;
  logic [N-1:0]  gnt_reg;
  logic [SW-1:0] ptr_reg;

  logic          ld;
  logic [SW-1:0] rr_cand;
  logic          rr_found;
  logic [SW-1:0] cand;
  logic          eligible;
  logic          xfer;
  logic [N-1:0]  cand_oh;
  logic [N-1:0]  rdy_vec;

  // The output slot can accept a word when it is empty or being drained this cycle.
  assign ld = !f_vld_reg || bus.F_RDY;

  // Search for the first valid channel, starting at the pointer and wrapping at N-1.
  always_comb begin : rr_search
    int idx;
    rr_cand  = '0;
    rr_found = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (!rr_found && bus.VLD_IN[idx]) begin
        rr_found = 1'b1;
        rr_cand  = SW'(idx);
      end
    end
  end

  always_comb begin : candidate
    cand     = '0;
    eligible = 1'b0;
    if (bus.MODE) begin
      cand     = rr_cand;
      eligible = rr_found;
    end else if (int'(bus.SEL) < N) begin
      cand     = bus.SEL;
      eligible = bus.VLD_IN[bus.SEL];
    end
  end

  assign xfer = RST_N && ld && eligible;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_oh
      assign cand_oh[gi] = (cand == SW'(gi));
      assign rdy_vec[gi] = xfer && cand_oh[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      f_reg     <= '0;
      f_vld_reg <= 1'b0;
      gnt_reg   <= '0;
      ptr_reg   <= '0;
    end else if (ld) begin
      if (eligible) begin
        f_reg     <= bus.DIN[cand*W +: W];
        f_vld_reg <= 1'b1;
        gnt_reg   <= cand_oh;
        if (bus.MODE) ptr_reg <= (cand == LAST) ? '0 : cand + 1'b1;
      end else begin
        // Nothing is eligible, so the slot empties. F keeps its last value.
        f_vld_reg <= 1'b0;
        gnt_reg   <= '0;
      end
    end
  end

  assign bus.RDY_IN = rdy_vec;
  assign bus.F      = f_reg;
  assign bus.F_VLD  = f_vld_reg;
  assign bus.GNT    = gnt_reg;
endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1 with two instances: N=4/W=8 and N=3/W=4.
// Table vectors carry expected handshake/grant values; a queue tracks expected output words.
module tb_mux_arb_nx1;
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  mux_arb_nx1_if #(.N(4), .W(8)) bus4 ();
  mux_arb_nx1_if #(.N(3), .W(4)) bus3 ();

  mux_arb_nx1 #(.N(4), .W(8)) u_dut4 (.CLK(CLK), .RST_N(RST_N), .bus(bus4));
  mux_arb_nx1 #(.N(3), .W(4)) u_dut3 (.CLK(CLK), .RST_N(RST_N), .bus(bus3));

  typedef struct {
    bit          n3;
    logic [3:0]  vld;
    logic [1:0]  sel;
    logic        mode;
    logic        frdy;
    logic [31:0] din;
    logic [3:0]  exp_rdy;
    logic        exp_fvld;
    logic [3:0]  exp_gnt;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] gnt;
  } exp_t;

  vec_t tbl[64];
  int   ntbl = 0;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_f4 = '0;
  logic [7:0] last_f3 = '0;

  task automatic add(input bit n3, input logic [3:0] vld, input logic [1:0] sel,
                     input logic mode, input logic frdy, input logic [31:0] din,
                     input logic [3:0] er, input logic ef, input logic [3:0] eg);
    tbl[ntbl] = '{n3, vld, sel, mode, frdy, din, er, ef, eg};
    ntbl++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [3:0] rdy, gnt;
    logic [7:0] f, data;
    logic       fvld;
    int         ch;
    exp_t       e;
    if (!v.n3) begin
      bus4.VLD_IN = v.vld; bus4.SEL = v.sel; bus4.MODE = v.mode;
      bus4.F_RDY = v.frdy; bus4.DIN = v.din;
    end else begin
      bus3.VLD_IN = v.vld[2:0]; bus3.SEL = v.sel; bus3.MODE = v.mode;
      bus3.F_RDY = v.frdy; bus3.DIN = v.din[11:0];
    end
    #1;
    rdy = v.n3 ? {1'b0, bus3.RDY_IN} : bus4.RDY_IN;
    check($sformatf("v%0d rdy_in", idx), 32'(rdy), 32'(v.exp_rdy));
    if (v.exp_rdy != 4'b0000) begin
      ch = 0;
      for (int i = 0; i < 4; i++) if (v.exp_rdy[i]) ch = i;
      data = v.n3 ? {4'h0, v.din[ch*4 +: 4]} : v.din[ch*8 +: 8];
      sb.push_back('{data: data, gnt: v.exp_rdy});
    end
    @(posedge CLK); #1;
    fvld = v.n3 ? bus3.F_VLD : bus4.F_VLD;
    gnt  = v.n3 ? {1'b0, bus3.GNT} : bus4.GNT;
    f    = v.n3 ? {4'h0, bus3.F} : bus4.F;
    check($sformatf("v%0d f_vld", idx), 32'(fvld), 32'(v.exp_fvld));
    check($sformatf("v%0d gnt", idx), 32'(gnt), 32'(v.exp_gnt));
    if (v.exp_rdy != 4'b0000) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d scoreboard empty actual=%h required=word", idx, f);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d f_data", idx), 32'(f), 32'(e.data));
        check($sformatf("v%0d f_src", idx), 32'(gnt), 32'(e.gnt));
        if (v.n3) last_f3 = e.data; else last_f4 = e.data;
      end
    end else begin
      check($sformatf("v%0d f_hold", idx), 32'(f), 32'(v.n3 ? last_f3 : last_f4));
    end
    $display("vec %0d n3=%0d vld=%b mode=%0d frdy=%0d rdy=%b gnt=%b f_vld=%0d f=%h",
             idx, v.n3, v.vld, v.mode, v.frdy, rdy, gnt, fvld, f);
  endtask

  int split;

  initial begin
    // Part one: the N=4 instance.
    add(0, 4'b0000, 2'd0, 0, 1, $urandom(), 4'b0000, 0, 4'b0000);
    add(0, 4'b0100, 2'd2, 0, 1, 32'h12A53456, 4'b0100, 1, 4'b0100);
    add(0, 4'b0100, 2'd1, 0, 1, $urandom(), 4'b0000, 0, 4'b0000);
    for (int r = 0; r < 8; r++)
      add(0, 4'b1111, 2'd0, 1, 1, $urandom(), 4'(1 << (r % 4)), 1, 4'(1 << (r % 4)));
    add(0, 4'b0100, 2'd0, 1, 1, $urandom(), 4'b0100, 1, 4'b0100);
    for (int r = 0; r < 4; r++) begin
      logic [3:0] g;
      g = (r % 2 == 0) ? 4'b1000 : 4'b0001;
      add(0, 4'b1001, 2'd0, 1, 1, $urandom(), g, 1, g);
    end
    add(0, 4'b0010, 2'd0, 1, 1, $urandom(), 4'b0010, 1, 4'b0010);
    for (int r = 0; r < 3; r++)
      add(0, 4'b0110, 2'd0, 1, 0, $urandom(), 4'b0000, 1, 4'b0010);
    add(0, 4'b0110, 2'd0, 1, 1, $urandom(), 4'b0100, 1, 4'b0100);
    add(0, 4'b0010, 2'd0, 1, 1, $urandom(), 4'b0010, 1, 4'b0010);
    add(0, 4'b1111, 2'd0, 1, 0, $urandom(), 4'b0000, 1, 4'b0010);
    split = ntbl;
    // Part two: the first grant after the reset, then the N=3 instance.
    add(0, 4'b1111, 2'd0, 1, 1, $urandom(), 4'b0001, 1, 4'b0001);
    add(1, 4'b0111, 2'd3, 0, 1, $urandom(), 4'b0000, 0, 4'b0000);
    for (int r = 0; r < 4; r++)
      add(1, 4'b0111, 2'd0, 1, 1, $urandom(), 4'(1 << (r % 3)), 1, 4'(1 << (r % 3)));
    add(1, 4'b0000, 2'd0, 1, 1, $urandom(), 4'b0000, 0, 4'b0000);

    // Hold reset for two cycles with every channel requesting.
    RST_N = 1'b0;
    bus4.VLD_IN = 4'b1111; bus4.SEL = '0; bus4.MODE = 1'b1; bus4.F_RDY = 1'b1; bus4.DIN = $urandom();
    bus3.VLD_IN = 3'b111;  bus3.SEL = '0; bus3.MODE = 1'b1; bus3.F_RDY = 1'b1; bus3.DIN = 12'h5A3;
    repeat (2) @(posedge CLK);
    #1;
    check("rst rdy_in4", 32'(bus4.RDY_IN), 32'h0);
    check("rst rdy_in3", 32'(bus3.RDY_IN), 32'h0);
    check("rst f4", 32'(bus4.F), 32'h0);
    check("rst f_vld4", 32'(bus4.F_VLD), 32'h0);
    check("rst gnt4", 32'(bus4.GNT), 32'h0);
    check("rst f_vld3", 32'(bus3.F_VLD), 32'h0);
    $display("reset hold: rdy4=%b f4=%h f_vld4=%0d gnt4=%b", bus4.RDY_IN, bus4.F, bus4.F_VLD, bus4.GNT);
    RST_N = 1'b1;
    bus4.VLD_IN = '0;
    bus3.VLD_IN = '0; bus3.MODE = 1'b0;

    for (int i = 0; i < split; i++) apply(tbl[i], i);

    // Reset lands while a word is held under back-pressure and the pointer is at 2.
    RST_N = 1'b0;
    #1;
    check("midrst rdy_in4", 32'(bus4.RDY_IN), 32'h0);
    @(posedge CLK); #1;
    check("midrst f4", 32'(bus4.F), 32'h0);
    check("midrst f_vld4", 32'(bus4.F_VLD), 32'h0);
    check("midrst gnt4", 32'(bus4.GNT), 32'h0);
    $display("mid-op reset: f4=%h f_vld4=%0d gnt4=%b", bus4.F, bus4.F_VLD, bus4.GNT);
    last_f4 = '0;
    last_f3 = '0;
    RST_N = 1'b1;

    for (int i = split; i < ntbl; i++) apply(tbl[i], i);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
